// File: rtl/d_mem_pkg.sv
// d_mem_pkg: shared funct3 codes, FSM states and fault codes for d_mem_hs
package d_mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} st_t;
  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_ILLEGAL  = 2'd1;
  localparam logic [1:0] FLT_MISALIGN = 2'd2;
  localparam logic [1:0] FLT_RANGE    = 2'd3;
endpackage

// File: rtl/d_mem_lane.sv
// d_mem_lane: byte-lane enables, write shifting, load align/extend and size faults
module d_mem_lane
  import d_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] ldata,
  output logic        misalign,
  output logic        illegal
);
  logic [31:0] sh;
  always_comb begin
    be       = funct3[1:0] == 2'b00 ? 4'b0001 << addr_lo :
               funct3[1:0] == 2'b01 ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wword    = wdata << {addr_lo, 3'b000};
    sh       = rword >> {addr_lo, 3'b000};
    ldata    = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
               funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
               funct3 == F3_BU ? {24'b0, sh[7:0]} :
               funct3 == F3_HU ? {16'b0, sh[15:0]} : rword;
    misalign = (funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
    illegal  = funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111;
  end
endmodule

// File: rtl/d_mem_hs.sv
// d_mem_hs: valid/ready RV32I data memory with fixed latency and fault responses (trace with D_MEM_TRACE_EN)
module d_mem_hs
  import d_mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 512,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  st_t         state;
  logic [3:0]  cnt;
  logic        r_we, a_we, misal, ill, oor, commit, accept;
  logic [2:0]  r_f3, a_f3;
  logic [31:0] r_addr, r_wdata, a_addr, a_wdata, rword, wword, ld;
  logic [3:0]  be;
  logic [1:0]  flt;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  always_comb begin
    accept = state == ST_IDLE && req_valid && req_ready;
    a_we    = state == ST_IDLE ? req_we     : r_we;
    a_f3    = state == ST_IDLE ? req_funct3 : r_f3;
    a_addr  = state == ST_IDLE ? req_addr   : r_addr;
    a_wdata = state == ST_IDLE ? req_wdata  : r_wdata;
    oor     = {2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS);
    idx     = oor ? '0 : a_addr[AW+1:2];
    rword   = mem[idx];
    flt     = (ill || (a_we && a_f3[2])) ? FLT_ILLEGAL : misal ? FLT_MISALIGN : oor ? FLT_RANGE : FLT_NONE;
    commit  = (accept && LATENCY == 1) || (state == ST_WAIT && cnt == 4'd0);
  end
  d_mem_lane u_lane (
    .funct3  (a_f3),
    .addr_lo (a_addr[1:0]),
    .wdata   (a_wdata),
    .rword   (rword),
    .be      (be),
    .wword   (wword),
    .ldata   (ld),
    .misalign(misal),
    .illegal (ill)
  );
  always_ff @(posedge clk)
    if (!rst && commit && a_we && flt == FLT_NONE)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (commit) begin
        state     <= ST_RESP;
        req_ready <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= flt != FLT_NONE;
        rsp_rdata <= (flt != FLT_NONE || a_we) ? '0 : ld;
      end else if (accept) begin
        state     <= ST_WAIT;
        req_ready <= 1'b0;
        cnt       <= 4'(LATENCY - 2);
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end else if (state == ST_RESP && rsp_ready) begin
        state     <= ST_IDLE;
        rsp_valid <= 1'b0;
        req_ready <= 1'b1;
      end
    end
`ifdef D_MEM_TRACE_EN
  always_ff @(posedge clk)
    if (!rst && commit)
      if (flt != FLT_NONE)
        $display("%0t d_mem fault addr=%h funct3=%b kind=%0d", $time, a_addr, a_f3, flt);
      else if (a_we)
        $display("%0t d_mem store addr=%h be=%b data=%h", $time, a_addr, be, wword);
`endif
endmodule

// File: tb/tb_d_mem_hs.sv
// tb_d_mem_hs: directed checks of d_mem_hs at latencies 1, 4 and 3
module tb_d_mem_hs;
  logic        clk = 1'b0;
  logic        rst;
  logic        rv [3];
  logic        rrdy [3];
  logic        we [3];
  logic [2:0]  f3 [3];
  logic [31:0] ad [3];
  logic [31:0] wd [3];
  logic        vld [3];
  logic        rp [3];
  logic [31:0] rdat [3];
  logic        rerr [3];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  d_mem_hs #(.DEPTH_WORDS(512), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rrdy[0]), .req_we(we[0]),
    .req_funct3(f3[0]), .req_addr(ad[0]), .req_wdata(wd[0]), .rsp_valid(vld[0]),
    .rsp_ready(rp[0]), .rsp_rdata(rdat[0]), .rsp_err(rerr[0]));
  d_mem_hs #(.DEPTH_WORDS(512), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rrdy[1]), .req_we(we[1]),
    .req_funct3(f3[1]), .req_addr(ad[1]), .req_wdata(wd[1]), .rsp_valid(vld[1]),
    .rsp_ready(rp[1]), .rsp_rdata(rdat[1]), .rsp_err(rerr[1]));
  d_mem_hs #(.DEPTH_WORDS(512), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rrdy[2]), .req_we(we[2]),
    .req_funct3(f3[2]), .req_addr(ad[2]), .req_wdata(wd[2]), .rsp_valid(vld[2]),
    .rsp_ready(rp[2]), .rsp_rdata(rdat[2]), .rsp_err(rerr[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input int k, input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    rv[k] = 1'b1;
    we[k] = w;
    f3[k] = f;
    ad[k] = a;
    wd[k] = d;
    @(posedge clk);
    #1;
    rv[k] = 1'b0;
  endtask
  task automatic wait_rsp(input int k, output int n);
    n = 1;
    while (!vld[k] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic consume(input int k);
    rp[k] = 1'b1;
    @(posedge clk);
    #1;
    rp[k] = 1'b0;
  endtask
  task automatic acc(input string tag, input int k, input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input int el, input logic [31:0] er, input logic ee);
    int n;
    chk({tag, ".rdy"}, 32'(rrdy[k]), 32'd1);
    issue(k, w, f, a, d);
    wait_rsp(k, n);
    chk({tag, ".lat"}, n, el);
    chk({tag, ".data"}, rdat[k], er);
    chk({tag, ".err"}, 32'(rerr[k]), {31'b0, ee});
    consume(k);
  endtask
  initial begin
    int n;
    logic [31:0] held;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rv[k] = 1'b0; we[k] = 1'b0; f3[k] = 3'b000; ad[k] = '0; wd[k] = '0; rp[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d.rdy", k), 32'(rrdy[k]), 32'd1);
      chk($sformatf("rst%0d.vld", k), 32'(vld[k]), 32'd0);
      chk($sformatf("rst%0d.data", k), rdat[k], 32'd0);
      chk($sformatf("rst%0d.err", k), 32'(rerr[k]), 32'd0);
    end
    acc("sw",       0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0);
    acc("lw",       0, 1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0);
    acc("sw2",      0, 1'b1, 3'b010, 32'h10, 32'h80FF7F01, 1, 32'h0, 1'b0);
    acc("lb",       0, 1'b0, 3'b000, 32'h12, 32'h0, 1, 32'hFFFFFFFF, 1'b0);
    acc("lbu",      0, 1'b0, 3'b100, 32'h12, 32'h0, 1, 32'h000000FF, 1'b0);
    acc("lh",       0, 1'b0, 3'b001, 32'h12, 32'h0, 1, 32'hFFFF80FF, 1'b0);
    acc("lhu",      0, 1'b0, 3'b101, 32'h10, 32'h0, 1, 32'h00007F01, 1'b0);
    acc("lb0",      0, 1'b0, 3'b000, 32'h10, 32'h0, 1, 32'h00000001, 1'b0);
    acc("sb",       0, 1'b1, 3'b000, 32'h13, 32'h555555AA, 1, 32'h0, 1'b0);
    acc("lw_sb",    0, 1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hAAFF7F01, 1'b0);
    acc("sh_mis",   0, 1'b1, 3'b001, 32'h11, 32'h1234, 1, 32'h0, 1'b1);
    acc("lw_shm",   0, 1'b0, 3'b010, 32'h10, 32'h0, 1, 32'hAAFF7F01, 1'b0);
    acc("sh",       0, 1'b1, 3'b001, 32'h12, 32'hFFFF1234, 1, 32'h0, 1'b0);
    acc("lw_sh",    0, 1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h12347F01, 1'b0);
    acc("lw_oor",   0, 1'b0, 3'b010, 32'h800, 32'h0, 1, 32'h0, 1'b1);
    acc("sw_top",   0, 1'b1, 3'b010, 32'h7FC, 32'h5A5A5A5A, 1, 32'h0, 1'b0);
    acc("lw_top",   0, 1'b0, 3'b010, 32'h7FC, 32'h0, 1, 32'h5A5A5A5A, 1'b0);
    acc("ld_f011",  0, 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1);
    acc("sw_f100",  0, 1'b1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1'b1);
    acc("lw_f100",  0, 1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h12347F01, 1'b0);
    acc("lw_mis",   0, 1'b0, 3'b010, 32'h12, 32'h0, 1, 32'h0, 1'b1);
    acc("lh_mis",   0, 1'b0, 3'b001, 32'h13, 32'h0, 1, 32'h0, 1'b1);
    acc("sw_wrap",  0, 1'b1, 3'b010, 32'h810, 32'h0, 1, 32'h0, 1'b1);
    acc("lw_wrap",  0, 1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h12347F01, 1'b0);
    acc("l4.sw",    1, 1'b1, 3'b010, 32'h4, 32'h0BADF00D, 4, 32'h0, 1'b0);
    issue(1, 1'b0, 3'b010, 32'h4, 32'h0);
    chk("l4.wait_rdy", 32'(rrdy[1]), 32'd0);
    wait_rsp(1, n);
    chk("l4.lat", n, 32'd4);
    chk("l4.data", rdat[1], 32'h0BADF00D);
    held = rdat[1];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("l4.hold_vld", 32'(vld[1]), 32'd1);
      chk("l4.hold_data", rdat[1], held);
      chk("l4.hold_rdy", 32'(rrdy[1]), 32'd0);
    end
    consume(1);
    chk("l4.post_rdy", 32'(rrdy[1]), 32'd1);
    chk("l4.post_vld", 32'(vld[1]), 32'd0);
    acc("l4.lbu",   1, 1'b0, 3'b100, 32'h5, 32'h0, 4, 32'h000000F0, 1'b0);
    acc("l3.sw",    2, 1'b1, 3'b010, 32'h20, 32'h11111111, 3, 32'h0, 1'b0);
    issue(2, 1'b1, 3'b010, 32'h20, 32'h22222222);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("l3.rst_rdy", 32'(rrdy[2]), 32'd1);
    chk("l3.rst_vld", 32'(vld[2]), 32'd0);
    acc("l3.lw",    2, 1'b0, 3'b010, 32'h20, 32'h0, 3, 32'h11111111, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
